// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: shares one cacheline adaptor between the I-cache (read
// only) and the D-cache (read / write-back). A winner is picked in IDLE, its
// request is latched and replayed to the adaptor until adp_resp, the response
// is routed back to that requester only, and a one-cycle GAP follows so the
// adaptor returns to its start state.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   -> on a tie, the requester that was not granted last wins
//   undefined -> fixed priority, D-cache wins whenever it requests
//
// Handshake: i_read, d_read and d_write are level requests that the requester
// holds until its one-cycle x_resp pulse; x_resp doubles as the acceptance and
// completion strobe, and a request still high after the pulse is a new one.
// Toward the adaptor, adp_read/adp_write stay high until the cycle adp_resp is
// seen, and adp_resp outside a grant is ignored.
module cacheline_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_line_o,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_line_i,
    output logic [LINE_W-1:0] d_line_o,
    output logic              d_resp,
    output logic [ADDR_W-1:0] adp_address,
    output logic              adp_read,
    output logic              adp_write,
    output logic [LINE_W-1:0] adp_line_o,
    input  logic [LINE_W-1:0] adp_line_i,
    input  logic              adp_resp,
    output logic [1:0]        dbg_state,
    output logic              dbg_last_grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    // last_grant_d_q: 0 = I-cache was served last, 1 = D-cache
    logic              last_grant_d_q;
    // adp_read_q / adp_write_q also hold the latched D-cache op
    logic              adp_read_q;
    logic              adp_write_q;
    logic              req_i;
    logic              req_d;
    logic              pick_d;

    // Winner selection for the IDLE decision
    always_comb begin
        req_i  = i_read;
        req_d  = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = req_d && (!req_i || !last_grant_d_q);
`else
        pick_d = req_d;
`endif
    end

    // Arbitration FSM with latched request and registered adaptor strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            last_grant_d_q <= 1'b0;
            adp_read_q     <= 1'b0;
            adp_write_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state       <= GRANT_D;
                        addr_q      <= d_address;
                        wdata_q     <= d_line_i;
                        // read+write together is treated as a write
                        adp_read_q  <= ~d_write;
                        adp_write_q <= d_write;
                    end else if (req_i) begin
                        state       <= GRANT_I;
                        addr_q      <= i_address;
                        adp_read_q  <= 1'b1;
                        adp_write_q <= 1'b0;
                    end
                end
                GRANT_I: begin
                    if (adp_resp) begin
                        state          <= GAP;
                        last_grant_d_q <= 1'b0;
                        adp_read_q     <= 1'b0;
                        adp_write_q    <= 1'b0;
                    end
                end
                GRANT_D: begin
                    if (adp_resp) begin
                        state          <= GAP;
                        last_grant_d_q <= 1'b1;
                        adp_read_q     <= 1'b0;
                        adp_write_q    <= 1'b0;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Response routing and adaptor-side outputs
    always_comb begin
        i_resp         = (state == GRANT_I) && adp_resp;
        d_resp         = (state == GRANT_D) && adp_resp;
        i_line_o       = adp_line_i;
        d_line_o       = adp_line_i;
        adp_address    = addr_q;
        adp_line_o     = wdata_q;
        adp_read       = adp_read_q;
        adp_write      = adp_write_q;
        dbg_state      = state;
        dbg_last_grant = last_grant_d_q;
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: directed bench for cacheline_arbiter with a
// transaction-level reference model, a grant-order scoreboard and a simple
// adaptor model that answers on the 6th cycle of each grant.
module tb_cacheline_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] i_address;
    logic          i_read;
    logic [LW-1:0] i_line_o;
    logic          i_resp;
    logic [AW-1:0] d_address;
    logic          d_read;
    logic          d_write;
    logic [LW-1:0] d_line_i;
    logic [LW-1:0] d_line_o;
    logic          d_resp;
    logic [AW-1:0] adp_address;
    logic          adp_read;
    logic          adp_write;
    logic [LW-1:0] adp_line_o;
    logic [LW-1:0] adp_line_i;
    logic          adp_resp;
    logic [1:0]    dbg_state;
    logic          dbg_last_grant;

    int checks   = 0;
    int failures = 0;

    // Scoreboard of expected completions: 1 = I-cache, 2 = D-cache
    logic [1:0] exp_q[$];

    // Adaptor model controls
    logic          spurious = 1'b0;
    logic [LW-1:0] resp_line;
    int            g_cnt = 0;

    // Reference model state (owner 0 = none, 1 = I, 2 = D)
    int            m_owner;
    bit            m_gap;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    bit            m_wr;
    int            m_last;
    int            win;
    logic [1:0]    got;

    localparam logic [LW-1:0] A5_LINE = {32{8'hA5}};
    localparam logic [LW-1:0] WPAT    = {4{64'h1122_3344_5566_7788}};

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_address      (i_address),
        .i_read         (i_read),
        .i_line_o       (i_line_o),
        .i_resp         (i_resp),
        .d_address      (d_address),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_line_i       (d_line_i),
        .d_line_o       (d_line_o),
        .d_resp         (d_resp),
        .adp_address    (adp_address),
        .adp_read       (adp_read),
        .adp_write      (adp_write),
        .adp_line_o     (adp_line_o),
        .adp_line_i     (adp_line_i),
        .adp_resp       (adp_resp),
        .dbg_state      (dbg_state),
        .dbg_last_grant (dbg_last_grant)
    );

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- adaptor model ----------------
    always @(posedge clk) begin
        #2;
        if (adp_read || adp_write) begin
            g_cnt++;
            adp_resp = (g_cnt == 6);
        end else begin
            g_cnt    = 0;
            adp_resp = spurious;
        end
        adp_line_i = resp_line;
    end

    // ---------------- reference model + compare ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            m_owner = 0;
            m_gap   = 0;
            m_addr  = '0;
            m_wdata = '0;
            m_wr    = 0;
            m_last  = 1;
            chk("rst_adp_read",  adp_read,  0);
            chk("rst_adp_write", adp_write, 0);
            chk("rst_i_resp",    i_resp,    0);
            chk("rst_d_resp",    d_resp,    0);
        end else begin
            chk("m_adp_read",   adp_read,  (m_owner == 1) || (m_owner == 2 && !m_wr));
            chk("m_adp_write",  adp_write, (m_owner == 2) && m_wr);
            chk("m_adp_address", adp_address, m_addr);
            chk("m_adp_line_o", adp_line_o, m_wdata);
            chk("m_i_resp",     i_resp, (m_owner == 1) && adp_resp);
            chk("m_d_resp",     d_resp, (m_owner == 2) && adp_resp);
            chk("m_i_line_o",   i_line_o, adp_line_i);
            chk("m_d_line_o",   d_line_o, adp_line_i);
            chk("m_last_grant", dbg_last_grant, m_last == 2);

            if (i_resp || d_resp) begin
                got = i_resp ? 2'd1 : 2'd2;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_resp", got, 0);
                end else begin
                    chk("sb_grant_order", got, exp_q.pop_front());
                end
            end

            // advance the model to the next edge using this cycle's inputs
            if (m_owner != 0) begin
                if (adp_resp) begin
                    m_last  = m_owner;
                    m_owner = 0;
                    m_gap   = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else begin
                win = 0;
                if (d_read || d_write) win = 2;
                else if (i_read) win = 1;
`ifdef ARB_ROUND_ROBIN_EN
                if (i_read && (d_read || d_write)) win = (m_last == 2) ? 1 : 2;
`endif
                if (win == 1) begin
                    m_owner = 1;
                    m_addr  = i_address;
                end else if (win == 2) begin
                    m_owner = 2;
                    m_addr  = d_address;
                    m_wr    = d_write;
                    m_wdata = d_line_i;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        i_read = 0; d_read = 0; d_write = 0;
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (i_resp || d_resp) begin
                n = k;
                break;
            end
        end
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout actual=none required=resp_within_60_cycles");
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int n;
        reset_n   = 1'b0;
        i_address = '0; i_read = 0;
        d_address = '0; d_read = 0; d_write = 0; d_line_i = '0;
        adp_resp  = 0;  adp_line_i = '0;
        resp_line = A5_LINE;

        // reset state
        @(negedge clk);
        chk("reset_adp_address", adp_address, 0);
        chk("reset_adp_line_o",  adp_line_o,  0);
        chk("reset_state_idle",  dbg_state,   0);
        chk("reset_last_grant_i", dbg_last_grant, 0);
        #1 reset_n = 1'b1;
        next_cycle();

        // I-cache read alone
        i_address = 32'h0000_1000;
        i_read    = 1;
        exp_q.push_back(2'd1);
        @(negedge clk);
        chk("i_pre_grant_read", adp_read, 0);
        @(negedge clk);
        chk("i_grant_read",    adp_read, 1);
        chk("i_grant_write",   adp_write, 0);
        chk("i_grant_address", adp_address, 32'h1000);
        wait_resp(n);
        chk("i_resp_at_6th_grant_cycle", n, 5);
        chk("i_resp_pulse", i_resp, 1);
        chk("i_line_value", i_line_o, A5_LINE);
        chk("i_no_d_resp",  d_resp, 0);
        next_cycle();
        i_read = 0;
        @(negedge clk);
        chk("gap_read",   adp_read, 0);
        chk("gap_write",  adp_write, 0);
        chk("gap_i_resp", i_resp, 0);
        next_cycle();

        // D-cache write-back, data changed after the grant
        d_address = 32'h8000_0040;
        d_line_i  = WPAT;
        d_write   = 1;
        exp_q.push_back(2'd2);
        next_cycle();
        next_cycle();
        d_line_i = '0;
        wait_resp(n);
        chk("d_wr_write",   adp_write, 1);
        chk("d_wr_read",    adp_read, 0);
        chk("d_wr_address", adp_address, 32'h8000_0040);
        chk("d_wr_data",    adp_line_o, WPAT);
        chk("d_wr_resp",    d_resp, 1);
        chk("d_wr_no_i",    i_resp, 0);
        next_cycle();
        d_write = 0;
        @(negedge clk);
        chk("d_resp_one_cycle", d_resp, 0);

        // simultaneous requests, both held
        do_reset();
        i_address = 32'h0000_0100;
        d_address = 32'h0000_0200;
        i_read = 1;
        d_read = 1;
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back(2'd2); exp_q.push_back(2'd1);
        exp_q.push_back(2'd2); exp_q.push_back(2'd1);
        for (int t = 0; t < 4; t++) wait_resp(n);
        next_cycle();
        i_read = 0;
        d_read = 0;
`else
        exp_q.push_back(2'd2); exp_q.push_back(2'd2);
        exp_q.push_back(2'd2); exp_q.push_back(2'd1);
        for (int t = 0; t < 3; t++) wait_resp(n);
        next_cycle();
        d_read = 0;
        wait_resp(n);
        chk("starved_i_served", i_resp, 1);
        next_cycle();
        i_read = 0;
`endif
        chk("tie_queue_drained", exp_q.size(), 0);

        // request changes mid-grant
        do_reset();
        i_address = 32'h0000_1000;
        i_read = 1;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        next_cycle();
        next_cycle();
        d_address = 32'h0000_3000;
        d_read    = 1;
        i_address = 32'h0000_2000;
        wait_resp(n);
        chk("mid_addr_held", adp_address, 32'h1000);
        chk("mid_i_resp",    i_resp, 1);
        next_cycle();
        i_read = 0;
        @(negedge clk);
        chk("mid_m1_read", adp_read, 0);
        @(negedge clk);
        chk("mid_m2_read", adp_read, 0);
        @(negedge clk);
        chk("mid_m3_read", adp_read, 1);
        chk("mid_m3_addr", adp_address, 32'h3000);
        wait_resp(n);
        next_cycle();
        d_read = 0;

        // async reset during GRANT_D
        do_reset();
        d_address = 32'h0000_4000;
        d_read = 1;
        next_cycle();
        @(negedge clk);
        chk("ar_granted", adp_read, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("ar_read_drop",  adp_read, 0);
        chk("ar_write_drop", adp_write, 0);
        chk("ar_no_d_resp",  d_resp, 0);
        chk("ar_state_idle", dbg_state, 0);
        d_read = 0;
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk("ar_idle_after_release", dbg_state, 0);
        end

        // spurious adaptor response while idle
        next_cycle();
        spurious = 1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("spur_state_idle", dbg_state, 0);
            chk("spur_no_i_resp",  i_resp, 0);
            chk("spur_no_d_resp",  d_resp, 0);
        end
        spurious = 0;
        next_cycle();
        next_cycle();

        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Two-port arbiter that shares the single cacheline adaptor (256-bit line ⇄ 4×64-bit burst) between the instruction cache (read-only) and the data cache (read/write). It sits between the two cache miss ports and the adaptor's LLC-side port. On grant it latches the winner's request and drives it to the adaptor. It routes the adaptor's one-cycle response back to that requester only, then inserts a one-cycle gap so the adaptor re-enters its start state cleanly.

## Interface
Parameters:
- ADDR_W, 32, address width
- LINE_W, 256, cacheline width

Ports:
- clk  in  1  clock; all state changes on posedge
- reset_n  in  1  reset, asynchronous, active-low
- i_address  in  ADDR_W  I-cache line address
- i_read  in  1  I-cache read request; level, held until i_resp
- i_line_o  out  LINE_W  line returned to I-cache
- i_resp  out  1  I-cache completion pulse
- d_address  in  ADDR_W  D-cache line address
- d_read  in  1  D-cache read request
- d_write  in  1  D-cache write-back request
- d_line_i  in  LINE_W  D-cache write-back data
- d_line_o  out  LINE_W  line returned to D-cache
- d_resp  out  1  D-cache completion pulse
- adp_address  out  ADDR_W  to adaptor address_i
- adp_read  out  1  to adaptor read_i
- adp_write  out  1  to adaptor write_i
- adp_line_o  out  LINE_W  to adaptor line_i
- adp_line_i  in  LINE_W  from adaptor line_o
- adp_resp  in  1  from adaptor resp_o

## Operation
- States: IDLE, GRANT_I, GRANT_D, GAP.
- IDLE:
  - Decide on the current cycle's requests.
  - Requests: I = i_read; D = d_read | d_write.
  - Winner selected per Configuration.
  - On a win, latch the winner's address into addr_q. For D, also latch op (write if d_write, else read) and d_line_i into wdata_q.
  - Go to GRANT_I or GRANT_D. With no request, stay in IDLE.
- GRANT_x:
  - adp_address = addr_q.
  - adp_read = 1 for I, or for D when op is read; adp_write = 1 for D when op is write.
  - adp_line_o = wdata_q.
  - Hold until adp_resp = 1. In that cycle assert x_resp = 1 combinationally, set last_grant = x, and go to GAP.
- GAP: all adp_* strobes 0, both resp 0; unconditionally go to IDLE next cycle.
- d_read and d_write both high: treated as a write.
- Outside GRANT states: adp_read = adp_write = 0; adp_address = addr_q; adp_line_o = wdata_q.
- i_line_o and d_line_o continuously follow adp_line_i. They are valid only in the cycle the matching resp is high.
- adp_resp outside a GRANT state is ignored and is not forwarded.
- Requester input changes after the grant are ignored until the next IDLE; the latched values are used.
- last_grant is a one-bit register, reset to I.

## Timing
- Reset (async assert, at any time including mid-transfer):
  - State forced to IDLE immediately.
  - addr_q, wdata_q, op and last_grant cleared (last_grant = I).
  - All adp_* outputs and i_resp/d_resp are 0 while reset_n = 0.
  - No response is generated for an aborted transfer; the adaptor is reset alongside.
- Grant latency: a request seen in IDLE at edge N makes adp_read/adp_write high from cycle N+1.
- Response: x_resp is in the same cycle as adp_resp, zero added latency.
- Turnaround: after adp_resp at cycle M, the earliest next adp strobe is at cycle M+3 (M+1 GAP, M+2 IDLE decides, M+3 GRANT).
- A requester deasserting its request in the cycle after its resp is not re-granted.
- Exactly one of i_resp/d_resp is high per transfer, for exactly one cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - If both I and D request in IDLE, the one not equal to last_grant wins.
  - A lone requester always wins.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: D wins whenever D requests; I is served only when D is idle.
  - last_grant is still maintained but unused.

## Test plan
- I-cache read alone:
  - i_read = 1, i_address = 0x0000_1000; adaptor model returns line 0xA5…A5 with adp_resp at the 6th GRANT cycle.
  - Required: adp_read from the cycle after the request, adp_address = 0x1000, adp_write = 0.
  - Required: i_resp pulses one cycle with i_line_o = 0xA5…A5; d_resp stays 0; GAP cycle has all strobes 0.
- D-cache write-back:
  - d_write = 1, d_address = 0x8000_0040, d_line_i = 0x1122…; d_line_i changed to 0 one cycle after the grant.
  - Required: adp_write = 1, adp_line_o = 0x1122… held until adp_resp; d_resp is one cycle.
- Simultaneous requests, both held continuously:
  - Round-robin: grants alternate D, I, D, I from reset.
  - Fixed priority: D, D, D; I starved until d_read/d_write drop.
- Request changes mid-grant:
  - During GRANT_I, d_read rises and i_address changes to 0x2000.
  - Required: adp_address stays 0x1000 until resp; D is granted at M+3.
- Async reset mid-burst: reset_n pulled low during GRANT_D.
  - Required: adp_read/adp_write drop to 0 without waiting for a clock edge; state is IDLE after release; no d_resp.
- Spurious adp_resp = 1 in IDLE:
  - Required: no i_resp/d_resp; state remains IDLE.
